// File: rtl/register_file_sb_pkg.sv
// Shared types and default sizes for the scoreboarded register file.
// Holds the soft-clear FSM state encoding and the default geometry.
package register_file_sb_pkg;

    localparam int unsigned DefDataW = 16;
    localparam int unsigned DefAddrW = 4;

    typedef enum logic [0:0] {
        StIdle  = 1'b0,
        StClear = 1'b1
    } rf_state_e;

endpackage

// File: rtl/register_file_sb_if.sv
// Decode/writeback-facing bus of the register file.
// The master side is the pipeline; the slave side is register_file_sb.
interface register_file_sb_if
    import register_file_sb_pkg::*;
#(
    parameter int unsigned DATA_W = DefDataW,
    parameter int unsigned ADDR_W = DefAddrW
) ();

    logic              w_en;
    logic [ADDR_W-1:0] addr_c;
    logic [DATA_W-1:0] data_c;
    logic              iss_en;
    logic [ADDR_W-1:0] iss_addr;
    logic              clr_req;
    logic [ADDR_W-1:0] addr_a;
    logic [ADDR_W-1:0] addr_b;
    logic [ADDR_W-1:0] addr_d;
    logic [DATA_W-1:0] data_a;
    logic [DATA_W-1:0] data_b;
    logic [DATA_W-1:0] data_d;
    logic              hz_a;
    logic              hz_b;
    logic              hz_d;
    logic              clr_busy;

    modport master (
        output w_en, addr_c, data_c, iss_en, iss_addr, clr_req, addr_a, addr_b, addr_d,
        input  data_a, data_b, data_d, hz_a, hz_b, hz_d, clr_busy
    );

    modport slave (
        input  w_en, addr_c, data_c, iss_en, iss_addr, clr_req, addr_a, addr_b, addr_d,
        output data_a, data_b, data_d, hz_a, hz_b, hz_d, clr_busy
    );

endinterface

// File: rtl/register_file_sb_rf_read_port.sv
// One combinational read port: storage mux, write bypass, zero-register
// masking and the pending-operand hazard flag.
module register_file_sb_rf_read_port
    import register_file_sb_pkg::*;
#(
    parameter int unsigned DATA_W   = DefDataW,
    parameter int unsigned ADDR_W   = DefAddrW,
    parameter bit          BYPASS   = 1'b1,
    parameter bit          ZERO_REG = 1'b0
) (
    input  logic [(2**ADDR_W)-1:0][DATA_W-1:0] regs_i,
    input  logic [(2**ADDR_W)-1:0]             pend_i,
    input  logic                               idle_i,
    input  logic                               w_en_i,
    input  logic [ADDR_W-1:0]                  addr_c_i,
    input  logic [DATA_W-1:0]                  data_c_i,
    input  logic [ADDR_W-1:0]                  addr_i,
    output logic [DATA_W-1:0]                  data_o,
    output logic                               hz_o
);

    logic is_zero;
    logic byp;

    assign is_zero = ZERO_REG && (addr_i == '0);
    assign byp     = BYPASS && idle_i && w_en_i && (addr_c_i == addr_i);

    always_comb begin
        data_o = regs_i[addr_i];
        hz_o   = 1'b1;
        if (is_zero) begin
            // The hardwired zero register is never a hazard, even mid-clear.
            data_o = '0;
            hz_o   = 1'b0;
        end else begin
            if (byp) begin
                data_o = data_c_i;
            end
            if (idle_i) begin
                hz_o = pend_i[addr_i] & ~byp;
            end
        end
    end

endmodule

// File: rtl/register_file_sb.sv
// Parametrised 3-read/1-write register file with write bypass, pending-write
// scoreboard and a sequenced soft-clear engine.
module register_file_sb
    import register_file_sb_pkg::*;
#(
    parameter int unsigned DATA_W   = DefDataW,
    parameter int unsigned ADDR_W   = DefAddrW,
    parameter bit          BYPASS   = 1'b1,
    parameter bit          ZERO_REG = 1'b0
) (
    input logic               clk,
    input logic               rst,
    register_file_sb_if.slave bus
);

    localparam int unsigned Depth = 2 ** ADDR_W;

    logic [Depth-1:0][DATA_W-1:0] regs_q, regs_d;
    logic [Depth-1:0]             pend_q, pend_d;
    rf_state_e                    state_q, state_d;
    logic [ADDR_W-1:0]            cnt_q, cnt_d;
    logic                         clr_busy_q, clr_busy_d;

    logic wr_ok;
    logic iss_ok;
    logic idle;

    assign idle   = (state_q == StIdle);
    assign wr_ok  = bus.w_en && !(ZERO_REG && (bus.addr_c == '0));
    assign iss_ok = bus.iss_en && !(ZERO_REG && (bus.iss_addr == '0));

    always_comb begin
        regs_d  = regs_q;
        pend_d  = pend_q;
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            StIdle: begin
                if (wr_ok) begin
                    regs_d[bus.addr_c] = bus.data_c;
                    pend_d[bus.addr_c] = 1'b0;
                end
                // Issue after writeback: a new producer keeps the register pending.
                if (iss_ok) begin
                    pend_d[bus.iss_addr] = 1'b1;
                end
                if (bus.clr_req) begin
                    pend_d  = '0;
                    cnt_d   = '0;
                    state_d = StClear;
                end
            end
            StClear: begin
                regs_d[cnt_q] = '0;
                if (cnt_q == ADDR_W'(Depth - 1)) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
        clr_busy_d = (state_d == StClear);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            regs_q     <= '0;
            pend_q     <= '0;
            state_q    <= StIdle;
            cnt_q      <= '0;
            clr_busy_q <= 1'b0;
        end else begin
            regs_q     <= regs_d;
            pend_q     <= pend_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            clr_busy_q <= clr_busy_d;
        end
    end

    assign bus.clr_busy = clr_busy_q;

    register_file_sb_rf_read_port #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .BYPASS  (BYPASS),
        .ZERO_REG(ZERO_REG)
    ) u_port_a (
        .regs_i  (regs_q),
        .pend_i  (pend_q),
        .idle_i  (idle),
        .w_en_i  (bus.w_en),
        .addr_c_i(bus.addr_c),
        .data_c_i(bus.data_c),
        .addr_i  (bus.addr_a),
        .data_o  (bus.data_a),
        .hz_o    (bus.hz_a)
    );

    register_file_sb_rf_read_port #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .BYPASS  (BYPASS),
        .ZERO_REG(ZERO_REG)
    ) u_port_b (
        .regs_i  (regs_q),
        .pend_i  (pend_q),
        .idle_i  (idle),
        .w_en_i  (bus.w_en),
        .addr_c_i(bus.addr_c),
        .data_c_i(bus.data_c),
        .addr_i  (bus.addr_b),
        .data_o  (bus.data_b),
        .hz_o    (bus.hz_b)
    );

    register_file_sb_rf_read_port #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .BYPASS  (BYPASS),
        .ZERO_REG(ZERO_REG)
    ) u_port_d (
        .regs_i  (regs_q),
        .pend_i  (pend_q),
        .idle_i  (idle),
        .w_en_i  (bus.w_en),
        .addr_c_i(bus.addr_c),
        .data_c_i(bus.data_c),
        .addr_i  (bus.addr_d),
        .data_o  (bus.data_d),
        .hz_o    (bus.hz_d)
    );

endmodule

// File: tb/tb_register_file_sb.sv
// Bench for register_file_sb: three configurations (default, no bypass,
// zero register) driven in lockstep and checked against an array model.
module tb_register_file_sb;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        w_en, iss_en, clr_req;
    logic [3:0]  addr_c, iss_addr, addr_a, addr_b, addr_d;
    logic [15:0] data_c;

    register_file_sb_if #(.DATA_W(16), .ADDR_W(4)) if0 ();
    register_file_sb_if #(.DATA_W(16), .ADDR_W(4)) if1 ();
    register_file_sb_if #(.DATA_W(16), .ADDR_W(4)) if2 ();

    assign if0.w_en = w_en;     assign if1.w_en = w_en;     assign if2.w_en = w_en;
    assign if0.addr_c = addr_c; assign if1.addr_c = addr_c; assign if2.addr_c = addr_c;
    assign if0.data_c = data_c; assign if1.data_c = data_c; assign if2.data_c = data_c;
    assign if0.iss_en = iss_en; assign if1.iss_en = iss_en; assign if2.iss_en = iss_en;
    assign if0.iss_addr = iss_addr; assign if1.iss_addr = iss_addr;
    assign if2.iss_addr = iss_addr;
    assign if0.clr_req = clr_req; assign if1.clr_req = clr_req; assign if2.clr_req = clr_req;
    assign if0.addr_a = addr_a; assign if1.addr_a = addr_a; assign if2.addr_a = addr_a;
    assign if0.addr_b = addr_b; assign if1.addr_b = addr_b; assign if2.addr_b = addr_b;
    assign if0.addr_d = addr_d; assign if1.addr_d = addr_d; assign if2.addr_d = addr_d;

    register_file_sb #(.DATA_W(16), .ADDR_W(4), .BYPASS(1'b1), .ZERO_REG(1'b0)) u_dut (
        .clk(clk), .rst(rst), .bus(if0)
    );
    register_file_sb #(.DATA_W(16), .ADDR_W(4), .BYPASS(1'b0), .ZERO_REG(1'b0)) u_dut_nb (
        .clk(clk), .rst(rst), .bus(if1)
    );
    register_file_sb #(.DATA_W(16), .ADDR_W(4), .BYPASS(1'b1), .ZERO_REG(1'b1)) u_dut_z (
        .clk(clk), .rst(rst), .bus(if2)
    );

    // Reference model: per-config register/pending arrays, one shared clear sequencer.
    logic [15:0] m_reg  [3][16];
    bit          m_pend [3][16];
    bit          m_clear;
    int          m_idx;

    int n_checks = 0;
    int n_errors = 0;
    int busy_cnt = 0;

    function automatic bit cfg_byp(int c);
        return c != 1;
    endfunction

    function automatic bit cfg_zero(int c);
        return c == 2;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < 3; c++) begin
            for (int r = 0; r < 16; r++) begin
                m_reg[c][r]  = '0;
                m_pend[c][r] = 1'b0;
            end
        end
        m_clear = 1'b0;
        m_idx   = 0;
    endtask

    task automatic model_edge();
        if (!m_clear) begin
            for (int c = 0; c < 3; c++) begin
                if (w_en && !(cfg_zero(c) && addr_c == 0)) begin
                    m_reg[c][addr_c]  = data_c;
                    m_pend[c][addr_c] = 1'b0;
                end
                if (iss_en && !(cfg_zero(c) && iss_addr == 0)) m_pend[c][iss_addr] = 1'b1;
                if (clr_req) begin
                    for (int r = 0; r < 16; r++) m_pend[c][r] = 1'b0;
                end
            end
            if (clr_req) begin
                m_clear = 1'b1;
                m_idx   = 0;
            end
        end else begin
            for (int c = 0; c < 3; c++) m_reg[c][m_idx] = '0;
            m_idx++;
            if (m_idx == 16) m_clear = 1'b0;
        end
    endtask

    task automatic exp_port(input int c, input int a, output logic [15:0] d, output logic h);
        bit byp;
        byp = cfg_byp(c) && !m_clear && w_en && (int'(addr_c) == a);
        if (cfg_zero(c) && a == 0) begin
            d = '0;
            h = 1'b0;
        end else begin
            d = byp ? data_c : m_reg[c][a];
            h = m_clear ? 1'b1 : (m_pend[c][a] && !byp);
        end
    endtask

    task automatic check_cfg(input int c, input logic [15:0] da, input logic [15:0] db,
                             input logic [15:0] dd, input logic ha, input logic hb,
                             input logic hd, input logic busy);
        logic [15:0] ed;
        logic        eh;
        exp_port(c, int'(addr_a), ed, eh);
        check_eq($sformatf("c%0d data_a", c), da, ed);
        check_eq($sformatf("c%0d hz_a", c), ha, eh);
        exp_port(c, int'(addr_b), ed, eh);
        check_eq($sformatf("c%0d data_b", c), db, ed);
        check_eq($sformatf("c%0d hz_b", c), hb, eh);
        exp_port(c, int'(addr_d), ed, eh);
        check_eq($sformatf("c%0d data_d", c), dd, ed);
        check_eq($sformatf("c%0d hz_d", c), hd, eh);
        check_eq($sformatf("c%0d clr_busy", c), busy, m_clear);
    endtask

    task automatic check_all();
        check_cfg(0, if0.data_a, if0.data_b, if0.data_d, if0.hz_a, if0.hz_b, if0.hz_d,
                  if0.clr_busy);
        check_cfg(1, if1.data_a, if1.data_b, if1.data_d, if1.hz_a, if1.hz_b, if1.hz_d,
                  if1.clr_busy);
        check_cfg(2, if2.data_a, if2.data_b, if2.data_d, if2.hz_a, if2.hz_b, if2.hz_d,
                  if2.clr_busy);
    endtask

    // Called just after a falling edge with inputs already driven.
    task automatic step();
        #1;
        check_all();
        if (if0.clr_busy) busy_cnt++;
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        w_en = 0; iss_en = 0; clr_req = 0;
        addr_c = 0; iss_addr = 0; data_c = 0;
    endtask

    task automatic fill_all();
        for (int i = 0; i < 16; i++) begin
            w_en = 1; addr_c = 4'(i); data_c = 16'(i * 16'h1111 + 16'h0101);
            step();
        end
        w_en = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 0;
        idle_inputs();
        addr_a = 0; addr_b = 0; addr_d = 0;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        check_all();
        check_eq("reset busy", if0.clr_busy, 1'b0);
        rst = 1;
        @(negedge clk);

        // Plain write then read back; untouched register stays zero.
        w_en = 1; addr_c = 5; data_c = 16'hBEEF;
        step();
        w_en = 0; addr_a = 5; addr_b = 3;
        #1;
        check_eq("rd reg5", if0.data_a, 16'hBEEF);
        check_eq("rd reg5 hz", if0.hz_a, 1'b0);
        check_eq("rd reg3", if0.data_b, 16'h0000);
        step();

        // Same-cycle bypass vs. no-bypass build.
        w_en = 1; addr_c = 7; data_c = 16'h1234; addr_b = 7;
        #1;
        check_eq("bypass on", if0.data_b, 16'h1234);
        check_eq("bypass off", if1.data_b, 16'h0000);
        step();
        w_en = 0;

        // Scoreboard: issue, writeback clears, issue+writeback keeps pending.
        iss_en = 1; iss_addr = 9;
        step();
        iss_en = 0; addr_d = 9;
        #1;
        check_eq("hz after issue", if0.hz_d, 1'b1);
        w_en = 1; addr_c = 9; data_c = 16'h0042;
        #1;
        check_eq("hz wb bypass", if0.hz_d, 1'b0);
        check_eq("hz wb nobypass", if1.hz_d, 1'b1);
        step();
        w_en = 0;
        #1;
        check_eq("hz after wb", if0.hz_d, 1'b0);
        check_eq("data after wb", if0.data_d, 16'h0042);
        w_en = 1; addr_c = 9; data_c = 16'h0055; iss_en = 1; iss_addr = 9;
        step();
        idle_inputs();
        #1;
        check_eq("hz issue wins", if0.hz_d, 1'b1);
        check_eq("data issue+wb", if0.data_d, 16'h0055);
        step();

        // Zero register ignores writes and issues.
        w_en = 1; addr_c = 0; data_c = 16'hFFFF; iss_en = 1; iss_addr = 0; addr_a = 0;
        step();
        idle_inputs();
        #1;
        check_eq("zero data", if2.data_a, 16'h0000);
        check_eq("zero hz", if2.hz_a, 1'b0);
        check_eq("reg0 normal", if0.data_a, 16'hFFFF);
        step();

        // Full soft clear with a dropped write and issue during it.
        fill_all();
        clr_req = 1;
        step();
        clr_req = 0; w_en = 1; addr_c = 4; data_c = 16'hABCD; iss_en = 1; iss_addr = 6;
        busy_cnt = 0;
        step();
        idle_inputs();
        for (int i = 0; i < 19; i++) begin
            addr_a = 4'($urandom); addr_b = 4'($urandom); addr_d = 4'($urandom);
            step();
        end
        check_eq("clear length", busy_cnt, 16);
        for (int i = 0; i < 16; i++) begin
            addr_a = 4'(i);
            #1;
            check_eq("cleared data", if0.data_a, 16'h0000);
            check_eq("cleared hz", if0.hz_a, 1'b0);
            step();
        end

        // Async reset in the fifth clear cycle, then a fresh full clear.
        fill_all();
        clr_req = 1; addr_a = 15;
        step();
        clr_req = 0;
        repeat (4) step();
        #2;
        rst = 0;
        #1;
        check_eq("rst busy0", if0.clr_busy, 1'b0);
        check_eq("rst busy1", if1.clr_busy, 1'b0);
        check_eq("rst busy2", if2.clr_busy, 1'b0);
        check_eq("rst reg15", if0.data_a, 16'h0000);
        model_reset();
        check_all();
        @(negedge clk);
        rst = 1;
        @(negedge clk);
        clr_req = 1;
        step();
        clr_req = 0;
        busy_cnt = 0;
        repeat (20) step();
        check_eq("clear length rerun", busy_cnt, 16);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            w_en = 1'($urandom); addr_c = 4'($urandom); data_c = 16'($urandom);
            iss_en = 1'($urandom); iss_addr = 4'($urandom);
            clr_req = ($urandom_range(0, 47) == 0);
            addr_a = 4'($urandom); addr_b = 4'($urandom);
            addr_d = ($urandom_range(0, 3) == 0) ? addr_c : 4'($urandom);
            step();
        end
        idle_inputs();
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
